enc_i2c: RTL and testbench
==========================

Name: enc_i2c

Overview:
Single-master I2C transaction generator, the transmit end of the link that dec_i2c decodes. On a start request it performs one complete transaction on SCL/SDA:
- START condition.
- 7-bit address plus R/W bit, then samples the slave ACK.
- One data byte: written, or read followed by a master NACK.
- STOP condition.

It sits between the system controller and the open-drain I2C pads, and is used as the bus driver for dec_i2c in loopback benches.

Parameters:
DIV, 4, clk cycles per SCL quarter-period (≥2); SCL period = 4*DIV clk cycles.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
iniciar  input  1  start request; sampled only when ocupado=0.
endereco  input  7  target slave address; latched at accept.
operacao  input  1  R/W bit: 0 = write, 1 = read; latched at accept.
dado_escrita  input  8  byte to write; latched at accept.
sda_i  input  1  resolved SDA bus level.
scl  output  1  SCL, push-pull.
sda_o  output  1  SDA control: 0 = pull low, 1 = release (open-drain).
ocupado  output  1  transaction in progress.
dado_lido  output  8  byte received in a read.
ack_erro  output  1  slave NACKed (address, or data in a write).
concluido  output  1  one-cycle pulse at transaction end.

Behaviour:
- Reset (reset=0, asynchronous): state OCIOSO, scl=1, sda_o=1, ocupado=0, dado_lido=0, ack_erro=0, concluido=0, all counters 0.
  - A reset mid-transaction aborts immediately and issues no STOP.
- Timing base: counter 0..DIV-1 produces a quarter tick when it reaches DIV-1.
  - Each bit is 4 quarters: Q0, Q1 with scl=0; Q2, Q3 with scl=1.
  - sda_o changes only at the start of Q0.
  - sda_i is sampled at the end of Q2.
- States:
  - OCIOSO:
    - scl=1, sda_o=1.
    - When iniciar=1, latch endereco, operacao, dado_escrita; clear ack_erro; set ocupado=1 on the next edge; go to START.
  - START:
    - 2 quarters with scl=1, sda_o=0 (SDA falls while SCL is high).
    - Then go to ENDERECO.
  - ENDERECO: 8 bits MSB first, {endereco, operacao}. Then ACK_END.
  - ACK_END:
    - Release SDA; sample sda_i.
    - If 1: ack_erro=1, go to STOP.
    - Else go to DADO_ESC (operacao=0) or DADO_LEI (operacao=1).
  - DADO_ESC: 8 bits of dado_escrita, MSB first. Then ACK_DADO.
  - ACK_DADO:
    - Release SDA; sample sda_i.
    - If 1, set ack_erro=1.
    - Always go to STOP.
  - DADO_LEI:
    - SDA released; shift sda_i in MSB first.
    - dado_lido updates once, after the 8th sample.
    - Then NACK_M.
  - NACK_M: master NACK, sda_o=1 for one bit time. Then STOP.
  - STOP:
    - Q0, Q1: scl=0, sda_o=0.
    - Q2: scl=1, sda_o=0.
    - Q3: scl=1, sda_o=1 (SDA rises while SCL is high).
    - At the end of Q3: concluido=1 for one clk, ocupado=0, go to OCIOSO.
- Lengths in quarters:
  - write, ACKed: 2+32+4+32+4+4 = 78.
  - read: 78.
  - address NACK: 2+32+4+4 = 42.
  - Latency from iniciar accept to concluido = quarters*DIV clk cycles.
- iniciar while ocupado=1 is ignored; inputs are not re-latched.
- iniciar held high continuously starts a new transaction on the cycle after concluido.
- dado_lido and ack_erro hold their values until the next accepted start.
- Any sda_i value other than 0 at an ACK sample (including X) is treated as NACK.

Test Plan:
1. Write, ACKed, DIV=4: endereco=1100100, operacao=0, dado_escrita=0xA5; bench pulls SDA low in both ACK slots.
   -> SDA shows START, 11001000, ACK, 10100101, ACK, STOP; ack_erro=0; concluido 312 cycles after accept.
2. Address NACK: endereco=1010101, SDA left released.
   -> address byte 10101010, then STOP with no data bits; ack_erro=1; concluido after 168 cycles.
3. Read: endereco=1100100, operacao=1; bench ACKs, then drives 0x3C.
   -> dado_lido=0x3C, SDA released during the 9th data-phase bit (NACK), STOP, ack_erro=0.
4. Loopback with dec_i2c (endereco_local=1100100):
   - write to 1100100 -> decoder endereco_recebido=1100100, operacao=0, stop asserted.
   - read -> operacao=1.
5. iniciar pulsed mid-transaction with different endereco -> ignored; waveform and latched values unchanged; exactly one concluido.
6. reset low during the ENDERECO phase -> same cycle: scl=1, sda_o=1, ocupado=0. After release, a new write completes normally.

Source files
------------

// File: rtl/enc_i2c_if.sv
`default_nettype none
// ============================================================================
// Module      : enc_i2c_if
// Description : Request/response and I2C pad signals of the enc_i2c master.
//               "slave" is the enc_i2c side; "master" is the controller side
//               that issues requests and resolves the open-drain SDA line.
// Revision    : 1.0 - initial release
// ============================================================================
interface enc_i2c_if;
  logic       iniciar;
  logic [6:0] endereco;
  logic       operacao;
  logic [7:0] dado_escrita;
  logic       sda_i;
  logic       scl;
  logic       sda_o;
  logic       ocupado;
  logic [7:0] dado_lido;
  logic       ack_erro;
  logic       concluido;

  modport slave (
    input  iniciar, endereco, operacao, dado_escrita, sda_i,
    output scl, sda_o, ocupado, dado_lido, ack_erro, concluido
  );

  modport master (
    output iniciar, endereco, operacao, dado_escrita, sda_i,
    input  scl, sda_o, ocupado, dado_lido, ack_erro, concluido
  );
endinterface
`default_nettype wire

// File: rtl/enc_i2c.sv
`default_nettype none
// ============================================================================
// Module      : enc_i2c
// Description : Single-master I2C transaction generator. One request yields
//               START, address+R/W, ACK, one data byte (write, or read plus
//               master NACK) and STOP. Each bit is four quarters of DIV clks.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_i2c #(
  parameter int DIV = 4
) (
  input wire         clk,
  input wire         reset,
  enc_i2c_if.slave   bus
);

  localparam int              c_DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(DIV - 1);

  typedef enum logic [3:0] {
    S_OCIOSO, S_START, S_ENDERECO, S_ACK_END, S_DADO_ESC,
    S_ACK_DADO, S_DADO_LEI, S_NACK_M, S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [c_DW-1:0] div_q, div_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      addr_q, addr_d;     // {endereco, operacao}
  logic [7:0]      dado_q, dado_d;
  logic [6:0]      sh_q, sh_d;         // first seven read bits
  logic            ack_ok_q, ack_ok_d;
  logic [7:0]      lido_q, lido_d;
  logic            ack_erro_q, ack_erro_d;
  logic            ocupado_q, ocupado_d;
  logic            concluido_q, concluido_d;

  logic w_tick, w_samp, w_bit_end, w_scl, w_sda;

  // Quarter tick; the divider only runs while a transaction is active.
  assign w_tick    = (state_q != S_OCIOSO) && (div_q == c_DIV_LAST);
  assign w_samp    = w_tick && (qtr_q == 2'd2);
  assign w_bit_end = w_tick && (qtr_q == 2'd3);

  // State and datapath registers; reset aborts without a STOP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_OCIOSO;
      div_q       <= '0;
      qtr_q       <= '0;
      bit_q       <= '0;
      addr_q      <= '0;
      dado_q      <= '0;
      sh_q        <= '0;
      ack_ok_q    <= 1'b0;
      lido_q      <= '0;
      ack_erro_q  <= 1'b0;
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      addr_q      <= addr_d;
      dado_q      <= dado_d;
      sh_q        <= sh_d;
      ack_ok_q    <= ack_ok_d;
      lido_q      <= lido_d;
      ack_erro_q  <= ack_erro_d;
      ocupado_q   <= ocupado_d;
      concluido_q <= concluido_d;
    end
  end

  // Next-state: timing counters, bus sampling and phase sequencing.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    qtr_d       = qtr_q;
    bit_d       = bit_q;
    addr_d      = addr_q;
    dado_d      = dado_q;
    sh_d        = sh_q;
    ack_ok_d    = ack_ok_q;
    lido_d      = lido_q;
    ack_erro_d  = ack_erro_q;
    ocupado_d   = ocupado_q;
    concluido_d = 1'b0;

    if (state_q != S_OCIOSO) begin
      div_d = w_tick ? '0 : div_q + c_DW'(1);
      if (w_tick) qtr_d = qtr_q + 2'd1;
    end

    // SDA is sampled at the end of Q2; anything but a clean 0 is a NACK.
    if (w_samp) begin
      if (bus.sda_i == 1'b0) ack_ok_d = 1'b1;
      else                   ack_ok_d = 1'b0;
      sh_d = {sh_q[5:0], bus.sda_i};
    end

    case (state_q)
      S_OCIOSO: begin
        if (bus.iniciar) begin
          addr_d     = {bus.endereco, bus.operacao};
          dado_d     = bus.dado_escrita;
          ack_erro_d = 1'b0;
          ocupado_d  = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (w_tick && (qtr_q == 2'd1)) begin
          qtr_d   = 2'd0;
          state_d = S_ENDERECO;
        end
      end
      S_ENDERECO: begin
        if (w_bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_ACK_END;
        end
      end
      S_ACK_END: begin
        if (w_bit_end) begin
          if (!ack_ok_q) begin
            ack_erro_d = 1'b1;
            state_d    = S_STOP;
          end else if (addr_q[0]) begin
            state_d = S_DADO_LEI;
          end else begin
            state_d = S_DADO_ESC;
          end
        end
      end
      S_DADO_ESC: begin
        if (w_bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_ACK_DADO;
        end
      end
      S_ACK_DADO: begin
        if (w_bit_end) begin
          if (!ack_ok_q) ack_erro_d = 1'b1;
          state_d = S_STOP;
        end
      end
      S_DADO_LEI: begin
        // The output byte is published only once all eight bits are in.
        if (w_samp && (bit_q == 3'd7)) lido_d = {sh_q, bus.sda_i};
        if (w_bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_NACK_M;
        end
      end
      S_NACK_M: begin
        if (w_bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (w_bit_end) begin
          ocupado_d   = 1'b0;
          concluido_d = 1'b1;
          state_d     = S_OCIOSO;
        end
      end
      default: state_d = S_OCIOSO;
    endcase
  end

  // Pad levels: SCL low in Q0/Q1, SDA only moves at bit boundaries except
  // for the START/STOP edges which happen while SCL is high.
  always_comb begin
    w_scl = 1'b1;
    w_sda = 1'b1;
    case (state_q)
      S_START: w_sda = 1'b0;
      S_ENDERECO: begin
        w_scl = qtr_q[1];
        w_sda = addr_q[~bit_q];
      end
      S_DADO_ESC: begin
        w_scl = qtr_q[1];
        w_sda = dado_q[~bit_q];
      end
      S_ACK_END, S_ACK_DADO, S_DADO_LEI, S_NACK_M: w_scl = qtr_q[1];
      S_STOP: begin
        w_scl = qtr_q[1];
        w_sda = (qtr_q == 2'd3);
      end
      default: ;
    endcase
  end

  assign bus.scl       = w_scl;
  assign bus.sda_o     = w_sda;
  assign bus.ocupado   = ocupado_q;
  assign bus.dado_lido = lido_q;
  assign bus.ack_erro  = ack_erro_q;
  assign bus.concluido = concluido_q;

endmodule
`default_nettype wire

// File: tb/tb_enc_i2c.sv
`default_nettype none
// ============================================================================
// Module      : tb_enc_i2c
// Description : Directed bench for enc_i2c with an I2C slave model on SDA and
//               a scoreboard of expected SDA bits and transaction results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enc_i2c;
  localparam int DIV = 4;

  typedef struct {
    int         nbits;
    int         lat;
    logic       ae;
    logic [7:0] lido;
  } res_t;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic slv_pull = 1'b0;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  logic       cfg_op    = 1'b0;
  logic       cfg_ack_a = 1'b0;
  logic       cfg_ack_d = 1'b0;
  logic [7:0] cfg_rd    = 8'h00;
  logic [7:0] mdl_lido  = 8'h00;

  logic exp_q[$];
  logic obs_q[$];
  res_t res_q[$];

  enc_i2c_if bus();
  assign bus.sda_i = bus.sda_o & ~slv_pull;

  enc_i2c #(.DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Record the SDA level at every SCL rise of an active transaction.
  always @(posedge bus.scl) begin
    #1;
    if (reset && bus.ocupado) obs_q.push_back(bus.sda_i);
  end

  // Slave model: tracks bit slots from START, drives ACK/read data while
  // SCL is low, counts STOP conditions.
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;
  int         bitn  = 0;
  int         stops = 0;
  logic [2:0] k;
  always @(bus.scl or bus.sda_i) begin
    if (p_scl && bus.scl && p_sda && !bus.sda_i) bitn = 0;
    if (p_scl && bus.scl && !p_sda && bus.sda_i && reset && bus.ocupado) stops++;
    if (!p_scl && bus.scl) bitn++;
    if (p_scl && !bus.scl) begin
      k = 3'(16 - bitn);
      if (bitn == 8)                      slv_pull = cfg_ack_a;
      else if (bitn >= 9 && bitn <= 16)   slv_pull = cfg_op && cfg_ack_a && !cfg_rd[k];
      else if (bitn == 17)                slv_pull = !cfg_op && cfg_ack_a && cfg_ack_d;
      else                                slv_pull = 1'b0;
    end
    p_scl = bus.scl;
    p_sda = bus.sda_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Queue the SDA bits and results an I2C transaction must produce.
  task automatic push_exp(input logic [6:0] a, input logic op, input logic [7:0] d,
                          input logic ack_a, input logic ack_d, input logic [7:0] rd);
    logic [7:0] ab;
    res_t       r;
    ab = {a, op};
    for (int i = 7; i >= 0; i--) exp_q.push_back(ab[i[2:0]]);
    exp_q.push_back(~ack_a);
    if (!ack_a) begin
      exp_q.push_back(1'b0);
      r.nbits = 10; r.lat = 42 * DIV; r.ae = 1'b1;
    end else begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(op ? rd[i[2:0]] : d[i[2:0]]);
      exp_q.push_back(op ? 1'b1 : ~ack_d);
      exp_q.push_back(1'b0);
      r.nbits = 19; r.lat = 78 * DIV; r.ae = op ? 1'b0 : ~ack_d;
      if (op) mdl_lido = rd;
    end
    r.lido = mdl_lido;
    res_q.push_back(r);
  endtask

  task automatic start(input logic [6:0] a, input logic op, input logic [7:0] d,
                       input logic ack_a, input logic ack_d, input logic [7:0] rd,
                       input bit hold);
    push_exp(a, op, d, ack_a, ack_d, rd);
    @(negedge clk);
    cfg_op = op; cfg_ack_a = ack_a; cfg_ack_d = ack_d; cfg_rd = rd;
    bus.endereco = a; bus.operacao = op; bus.dado_escrita = d; bus.iniciar = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.iniciar = 1'b0;
    chk("ocupado_accept", bus.ocupado, 1);
  endtask

  // Wait (bounded) for concluido, then pop and compare the scoreboard.
  task automatic wait_done(input int poke_at);
    int   n   = 0;
    logic got = 1'b0;
    int   s0;
    res_t r;
    logic eb, ob;
    s0 = stops;
    while (!got && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (poke_at > 0 && n == poke_at) begin
        bus.iniciar = 1'b1; bus.endereco = 7'h7F; bus.operacao = 1'b1; bus.dado_escrita = 8'hFF;
      end
      if (poke_at > 0 && n == poke_at + 1) bus.iniciar = 1'b0;
      got = bus.concluido;
    end
    chk("done_seen", got, 1);
    r = res_q.pop_front();
    chk("latency", n, r.lat);
    chk("ack_erro", bus.ack_erro, r.ae);
    chk("dado_lido", bus.dado_lido, r.lido);
    chk("ocupado_end", bus.ocupado, 0);
    chk("stop_seen", stops - s0, 1);
    chk("nbits", obs_q.size(), r.nbits);
    for (int j = 0; j < r.nbits; j++) begin
      eb = exp_q.pop_front();
      ob = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bx;
      chk($sformatf("sda_bit%0d", j), ob, eb);
    end
    obs_q.delete();
  endtask

  initial begin
    int extra;
    bus.iniciar = 1'b0; bus.endereco = '0; bus.operacao = 1'b0; bus.dado_escrita = '0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", bus.scl, 1);
    chk("rst_sda_o", bus.sda_o, 1);
    chk("rst_ocupado", bus.ocupado, 0);
    chk("rst_dado_lido", bus.dado_lido, 0);
    chk("rst_ack_erro", bus.ack_erro, 0);
    chk("rst_concluido", bus.concluido, 0);
    @(negedge clk) reset = 1'b1;

    // Write, both ACK slots acknowledged.
    start(7'b1100100, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0);
    wait_done(0);
    // Address NACK: slave leaves SDA released.
    start(7'b1010101, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0);
    wait_done(0);
    // Read of 0x3C, ack_erro must clear at accept.
    start(7'b1100100, 1'b1, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0);
    wait_done(0);
    // Write with data NACK; dado_lido holds the previous read.
    start(7'b1100100, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0);
    wait_done(0);

    // Start request during a transaction is ignored.
    start(7'h12, 1'b0, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b0);
    wait_done(100);
    extra = 0;
    repeat (400) begin
      @(posedge clk);
      #1;
      if (bus.concluido === 1'b1) extra++;
    end
    chk("extra_concluido", extra, 0);
    chk("idle_after_poke", bus.ocupado, 0);

    // iniciar held high: next transaction accepted right after concluido.
    start(7'h55, 1'b0, 8'h81, 1'b1, 1'b1, 8'h00, 1'b1);
    wait_done(0);
    push_exp(7'h55, 1'b0, 8'h81, 1'b1, 1'b1, 8'h00);
    @(posedge clk);
    #1;
    bus.iniciar = 1'b0;
    chk("b2b_accept", bus.ocupado, 1);
    wait_done(0);

    // Asynchronous reset in the address phase.
    start(7'b1100100, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00, 1'b0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_scl", bus.scl, 1);
    chk("abort_sda_o", bus.sda_o, 1);
    chk("abort_ocupado", bus.ocupado, 0);
    chk("abort_dado_lido", bus.dado_lido, 0);
    exp_q.delete();
    res_q.delete();
    obs_q.delete();
    mdl_lido = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    start(7'b1100100, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00, 1'b0);
    wait_done(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
